// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache/RAM arbiter.
//   arb_state_t : arbiter FSM states (suffixed to avoid clashing with cache IDLE)
//   ramstate_t  : RAM status encoding presented on the ramstate port
package mem_arbiter_pkg;

    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE_ARB = 2'd0,
        IGNT_ARB = 2'd1,
        DGNT_ARB = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction and data caches.
// Dcache has priority; a saturating counter bounds icache starvation.
// Every completed transfer returns through IDLE, where arbitration happens.
// Ports:
//   CLK, nRST                 clock (rising edge), async active-low reset
//   iREN, iaddr               icache read request / word address
//   iwait, iload              icache stall (low on ACCESS of its grant) / read data
//   dREN, dWEN, daddr, dstore dcache read / write request, address, write data
//   dwait, dload              dcache stall (low on ACCESS of its grant) / read data
//   ramREN, ramWEN, ramaddr, ramstore   RAM strobes, address, write data
//   ramload, ramstate         RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   mem_err                   sticky: RAM reported ERROR during a grant
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                mem_err_q, mem_err_d;
    ramstate_t           rs;
    logic                dreq;

    assign rs      = ramstate_t'(ramstate);
    assign dreq    = dREN | dWEN;
    assign iload   = ramload;
    assign dload   = ramload;
    assign mem_err = mem_err_q;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_err_d    = mem_err_q;
        iwait        = 1'b1;
        dwait        = 1'b1;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        case (state_q)
            IDLE_ARB: begin
                if (!iREN) starve_cnt_d = '0;
                if (dreq && (!iREN || (starve_cnt_q < STARVE_LIM))) state_d = DGNT_ARB;
                else if (iREN)                                       state_d = IGNT_ARB;
            end

            IGNT_ARB: begin
                // Strobe follows the live request so a dropped request never reaches RAM.
                ramREN  = iREN;
                ramaddr = iaddr;
                if (rs == ERROR) mem_err_d = 1'b1;
                if (!iREN) begin
                    state_d = IDLE_ARB;
                end else if (rs == ACCESS) begin
                    iwait        = 1'b0;
                    starve_cnt_d = '0;
                    state_d      = IDLE_ARB;
                end
            end

            DGNT_ARB: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;  // write wins when both are asserted
                if (rs == ERROR) mem_err_d = 1'b1;
                if (!dreq) begin
                    state_d = IDLE_ARB;
                end else if (rs == ACCESS) begin
                    dwait   = 1'b0;
                    state_d = IDLE_ARB;
                    if (iREN && (starve_cnt_q < STARVE_LIM))
                        starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE_ARB;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE_ARB;
            starve_cnt_q <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_err_q    <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        i_ren, d_ren, d_wen;
        logic [31:0] ia, da, ds, rl;
        logic [1:0]  rs;
        logic        e_iwait, e_dwait, e_ren, e_wen;
        logic [31:0] e_addr, e_store;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(logic i_ren, logic d_ren, logic d_wen,
                                logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                                logic [1:0] rs, logic [31:0] rl,
                                logic e_iwait, logic e_dwait, logic e_ren, logic e_wen,
                                logic [31:0] e_addr, logic [31:0] e_store);
        vec_t v;
        v.i_ren = i_ren; v.d_ren = d_ren; v.d_wen = d_wen;
        v.ia = ia; v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
        v.e_iwait = e_iwait; v.e_dwait = e_dwait; v.e_ren = e_ren; v.e_wen = e_wen;
        v.e_addr = e_addr; v.e_store = e_store;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic i_r, input logic d_r, input logic d_w,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input logic [1:0] rs);
        iREN = i_r; dREN = d_r; dWEN = d_w;
        iaddr = ia; daddr = da; dstore = ds; ramstate = rs;
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;

        tbl[0]  = mk(1,0,0, 32'h40,0,0,                       RS_FREE, 32'h0,        1,1,0,0, 32'h0,   32'h0);
        tbl[1]  = mk(1,0,0, 32'h40,0,0,                       RS_BUSY, 32'h11111111, 1,1,1,0, 32'h40,  32'h0);
        tbl[2]  = mk(1,0,0, 32'h40,0,0,                       RS_BUSY, 32'h22222222, 1,1,1,0, 32'h40,  32'h0);
        tbl[3]  = mk(1,0,0, 32'h40,0,0,                       RS_ACC,  32'h8C220004, 0,1,1,0, 32'h40,  32'h0);
        tbl[4]  = mk(0,0,0, 0,0,0,                            RS_FREE, 32'h0,        1,1,0,0, 32'h0,   32'h0);
        tbl[5]  = mk(1,0,1, 32'h44,32'h100,32'hDEADBEEF,      RS_FREE, 32'h0,        1,1,0,0, 32'h0,   32'h0);
        tbl[6]  = mk(1,0,1, 32'h44,32'h100,32'hDEADBEEF,      RS_ACC,  32'h0,        1,0,0,1, 32'h100, 32'hDEADBEEF);
        tbl[7]  = mk(1,0,0, 32'h44,32'h100,32'hDEADBEEF,      RS_FREE, 32'h0,        1,1,0,0, 32'h0,   32'h0);
        tbl[8]  = mk(1,0,0, 32'h44,32'h100,32'hDEADBEEF,      RS_ACC,  32'hCAFEF00D, 0,1,1,0, 32'h44,  32'h0);
        tbl[9]  = mk(0,0,0, 0,0,0,                            RS_FREE, 32'h0,        1,1,0,0, 32'h0,   32'h0);
        tbl[10] = mk(0,1,1, 0,32'h300,32'h12345678,           RS_FREE, 32'h0,        1,1,0,0, 32'h0,   32'h0);
        tbl[11] = mk(0,1,1, 0,32'h300,32'h12345678,           RS_BUSY, 32'h0,        1,1,0,1, 32'h300, 32'h12345678);
        tbl[12] = mk(0,1,1, 0,32'h300,32'h12345678,           RS_ACC,  32'h0,        1,0,0,1, 32'h300, 32'h12345678);
        tbl[13] = mk(0,0,0, 0,0,0,                            RS_FREE, 32'h0,        1,1,0,0, 32'h0,   32'h0);

        #12;
        chk("reset iwait",   32'(iwait),   32'h1);
        chk("reset dwait",   32'(dwait),   32'h1);
        chk("reset ramREN",  32'(ramREN),  32'h0);
        chk("reset ramWEN",  32'(ramWEN),  32'h0);
        chk("reset ramaddr", ramaddr,      32'h0);
        chk("reset mem_err", 32'(mem_err), 32'h0);
        tick();
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            ramload = tbl[i].rl;
            drive(tbl[i].i_ren, tbl[i].d_ren, tbl[i].d_wen, tbl[i].ia, tbl[i].da, tbl[i].ds, tbl[i].rs);
            chk($sformatf("v%0d iwait", i),    32'(iwait),  32'(tbl[i].e_iwait));
            chk($sformatf("v%0d dwait", i),    32'(dwait),  32'(tbl[i].e_dwait));
            chk($sformatf("v%0d ramREN", i),   32'(ramREN), 32'(tbl[i].e_ren));
            chk($sformatf("v%0d ramWEN", i),   32'(ramWEN), 32'(tbl[i].e_wen));
            chk($sformatf("v%0d ramaddr", i),  ramaddr,     tbl[i].e_addr);
            chk($sformatf("v%0d ramstore", i), ramstore,    tbl[i].e_store);
            chk($sformatf("v%0d iload", i),    iload,       tbl[i].rl);
            chk($sformatf("v%0d dload", i),    dload,       tbl[i].rl);
            tick();
        end

        // Two-word writeback: one IDLE bubble between the words.
        drive(0,0,1, 0,32'h200,32'hA0A0A0A0, RS_FREE);
        tick();
        drive(0,0,1, 0,32'h200,32'hA0A0A0A0, RS_ACC);
        chk("wb1 dwait",   32'(dwait),  32'h0);
        chk("wb1 ramaddr", ramaddr,     32'h200);
        tick();
        drive(0,0,1, 0,32'h204,32'hB1B1B1B1, RS_FREE);
        chk("wb bubble ramWEN", 32'(ramWEN), 32'h0);
        chk("wb bubble dwait",  32'(dwait),  32'h1);
        tick();
        drive(0,0,1, 0,32'h204,32'hB1B1B1B1, RS_ACC);
        chk("wb2 ramWEN",   32'(ramWEN), 32'h1);
        chk("wb2 ramaddr",  ramaddr,     32'h204);
        chk("wb2 ramstore", ramstore,    32'hB1B1B1B1);
        chk("wb2 dwait",    32'(dwait),  32'h0);
        tick();
        drive(0,0,0, 0,0,0, RS_FREE);
        tick();

        // Starvation: both requests held, RAM always ready. Two rounds show the counter restarts at 0.
        drive(1,1,0, 32'h80,32'h500,0, RS_ACC);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("stv r%0d k%0d idle ramREN", r, k), 32'(ramREN), 32'h0);
                tick();
                if (k < 4) begin
                    chk($sformatf("stv r%0d k%0d dwait", r, k), 32'(dwait), 32'h0);
                    chk($sformatf("stv r%0d k%0d iwait", r, k), 32'(iwait), 32'h1);
                    chk($sformatf("stv r%0d k%0d addr", r, k),  ramaddr,    32'h500);
                end else begin
                    chk($sformatf("stv r%0d igrant iwait", r), 32'(iwait), 32'h0);
                    chk($sformatf("stv r%0d igrant dwait", r), 32'(dwait), 32'h1);
                    chk($sformatf("stv r%0d igrant addr", r),  ramaddr,    32'h80);
                end
                tick();
            end
        end
        drive(0,0,0, 0,0,0, RS_FREE);
        tick();

        // ERROR during IGNT: wait held, sticky mem_err.
        chk("pre err mem_err", 32'(mem_err), 32'h0);
        drive(1,0,0, 32'h60,0,0, RS_FREE);
        tick();
        drive(1,0,0, 32'h60,0,0, RS_ERR);
        chk("err iwait",  32'(iwait),  32'h1);
        chk("err ramREN", 32'(ramREN), 32'h1);
        tick();
        drive(1,0,0, 32'h60,0,0, RS_ACC);
        chk("err then acc iwait",  32'(iwait),   32'h0);
        chk("err then acc mem_err", 32'(mem_err), 32'h1);
        tick();
        drive(0,0,0, 0,0,0, RS_FREE);
        chk("err sticky mem_err", 32'(mem_err), 32'h1);
        tick();

        // Reset mid-DGNT write: strobes drop asynchronously.
        drive(0,0,1, 0,32'h700,32'h55AA55AA, RS_FREE);
        tick();
        drive(0,0,1, 0,32'h700,32'h55AA55AA, RS_BUSY);
        chk("pre rst ramWEN", 32'(ramWEN), 32'h1);
        #2;
        nRST = 1'b0;
        #1;
        chk("async rst ramWEN",  32'(ramWEN),  32'h0);
        chk("async rst dwait",   32'(dwait),   32'h1);
        chk("async rst ramaddr", ramaddr,      32'h0);
        drive(0,0,0, 0,0,0, RS_FREE);
        tick();
        nRST = 1'b1;
        tick();
        chk("post rst mem_err", 32'(mem_err), 32'h0);
        chk("post rst ramWEN",  32'(ramWEN),  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
